// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - SHA-256 types, round constants, IVs and bit functions shared by the core.
package sha256_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

    // Working variables a..h; a occupies the top word.
    typedef struct packed {
        word_t a, b, c, d, e, f, g, h;
    } vars_t;

    localparam word_t K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam word_t IV256 [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam word_t IV224 [0:7] = '{
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t sig0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t sig1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic word_t bsig0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t bsig1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t ch(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic word_t maj(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

// File: rtl/sha256_round.sv
// rtl/sha256_round.sv - one combinational SHA-256 compression round.
module sha256_round
    import sha256_pkg::*;
(
    input  vars_t cur,
    input  word_t k,
    input  word_t w,
    output vars_t nxt
);

    word_t t1;
    word_t t2;

    assign t1 = cur.h + bsig1(cur.e) + ch(cur.e, cur.f, cur.g) + k + w;
    assign t2 = bsig0(cur.a) + maj(cur.a, cur.b, cur.c);

    assign nxt = '{a: t1 + t2, b: cur.a, c: cur.b, d: cur.c,
                   e: cur.d + t1, f: cur.e, g: cur.f, h: cur.g};

endmodule

// File: rtl/sha256_iter_core.sv
// rtl/sha256_iter_core.sv - multi-block SHA-256 core, RPC rounds per clock; SHA224_EN adds SHA-224 mode.
module sha256_iter_core
    import sha256_pkg::*;
#(
    parameter int RPC      = 1,
    parameter bit OUT_HOLD = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [511:0] blk_data,
    input  logic         blk_valid,
    input  logic         blk_first,
    input  logic         blk_last,
`ifdef SHA224_EN
    input  logic         mode224,
`endif
    output logic         blk_ready,
    output logic         busy,
    output logic [255:0] digest,
    output logic         digest_valid
);

    if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 8)) begin : g_bad_rpc
        $error("sha256_iter_core: RPC must be 1, 2, 4 or 8");
    end

    state_t           state, state_nxt;
    logic [511:0]     wv;          // W[t] in the top word, W[t+15] in the bottom
    logic [32*RPC-1:0] nw_flat;
    vars_t            work;
    word_t            h [0:7];
    word_t            iv [0:7];
    logic [255:0]     hsum;
    logic [255:0]     dig_r;
    logic             dig_v;
    logic [5:0]       cnt;
    logic             last;
    logic             accept;
    logic             done;
`ifdef SHA224_EN
    logic             m224;
`endif

    assign accept = blk_valid && blk_ready;
    assign done   = (cnt == 6'(64 - RPC));

    // New schedule words W[t+16+j]; later words may depend on ones made this cycle.
    for (genvar j = 0; j < RPC; j++) begin : g_sched
        word_t s2, s7, nw;
        if (j < 2) begin : g_s2w
            assign s2 = wv[511-32*(14+j) -: 32];
        end else begin : g_s2n
            assign s2 = g_sched[j-2].nw;
        end
        if (j < 7) begin : g_s7w
            assign s7 = wv[511-32*(9+j) -: 32];
        end else begin : g_s7n
            assign s7 = g_sched[j-7].nw;
        end
        assign nw = sig1(s2) + s7 + sig0(wv[511-32*(1+j) -: 32]) + wv[511-32*j -: 32];
        assign nw_flat[32*(RPC-j)-1 -: 32] = nw;
    end

    for (genvar j = 0; j < RPC; j++) begin : g_rnd
        vars_t      cur, nxt;
        logic [5:0] kidx;
        if (j == 0) begin : g_first
            assign cur = work;
        end else begin : g_next
            assign cur = g_rnd[j-1].nxt;
        end
        assign kidx = cnt + 6'(j);
        sha256_round u_round (
            .cur (cur),
            .k   (K[kidx]),
            .w   (wv[511-32*j -: 32]),
            .nxt (nxt)
        );
    end

    always_comb begin
        for (int i = 0; i < 8; i++) begin
`ifdef SHA224_EN
            iv[i] = mode224 ? IV224[i] : IV256[i];
`else
            iv[i] = IV256[i];
`endif
        end
    end

    always_comb begin
        hsum = '0;
        for (int i = 0; i < 8; i++) begin
            hsum[255-32*i -: 32] = h[i] + work[255-32*i -: 32];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ROUND;
            ROUND:   if (done) state_nxt = FINAL;
            FINAL:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        blk_ready = (state == IDLE) && !rst;
        busy      = (state == ROUND) || (state == FINAL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) h[i] <= IV256[i];
            wv    <= '0;
            work  <= '0;
            cnt   <= '0;
            last  <= 1'b0;
            dig_r <= '0;
            dig_v <= 1'b0;
`ifdef SHA224_EN
            m224  <= 1'b0;
`endif
        end else begin
            dig_v <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        wv   <= blk_data;
                        work <= blk_first ? {iv[0], iv[1], iv[2], iv[3], iv[4], iv[5], iv[6], iv[7]}
                                          : {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
                        if (blk_first) begin
                            for (int i = 0; i < 8; i++) h[i] <= iv[i];
`ifdef SHA224_EN
                            m224 <= mode224;
`endif
                        end
                        last <= blk_last;
                        cnt  <= '0;
                    end
                end
                ROUND: begin
                    work <= g_rnd[RPC-1].nxt;
                    wv   <= {wv[511-32*RPC:0], nw_flat};
                    cnt  <= cnt + 6'(RPC);
                end
                FINAL: begin
                    for (int i = 0; i < 8; i++) h[i] <= hsum[255-32*i -: 32];
                    if (last) begin
`ifdef SHA224_EN
                        dig_r <= m224 ? {hsum[255:32], 32'h0} : hsum;
`else
                        dig_r <= hsum;
`endif
                        dig_v <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign digest       = (OUT_HOLD || dig_v) ? dig_r : '0;
    assign digest_valid = dig_v;

endmodule

// File: tb/tb_sha256_iter_core.sv
// tb/tb_sha256_iter_core.sv - directed vector bench for sha256_iter_core (RPC=1 hold, RPC=4 zeroing).
module tb_sha256_iter_core;

    localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] BLK_TWO1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                          32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                          32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                          32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] BLK_TWO2  = {480'h0, 32'h000001c0};
    localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] D_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    typedef struct {
        logic [511:0] blk;
        logic         first;
        logic         last;
        logic [255:0] exp;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [511:0] blk_data = '0;
    logic         blk_first = 1'b0;
    logic         blk_last = 1'b0;
    logic         v1 = 1'b0, v4 = 1'b0;
    logic         rdy1, rdy4, busy1, busy4, dv1, dv4;
    logic [255:0] dg1, dg4;
`ifdef SHA224_EN
    logic         m224 = 1'b0;
`endif

    int nchk = 0;
    int nerr = 0;
    logic [255:0] hold1 = '0;
    vec_t tbl [5];

    always #5 clk = ~clk;

    sha256_iter_core #(.RPC(1), .OUT_HOLD(1'b1)) dut1 (
        .clk(clk), .rst(rst), .blk_data(blk_data), .blk_valid(v1),
        .blk_first(blk_first), .blk_last(blk_last),
`ifdef SHA224_EN
        .mode224(m224),
`endif
        .blk_ready(rdy1), .busy(busy1), .digest(dg1), .digest_valid(dv1)
    );

    sha256_iter_core #(.RPC(4), .OUT_HOLD(1'b0)) dut4 (
        .clk(clk), .rst(rst), .blk_data(blk_data), .blk_valid(v4),
        .blk_first(blk_first), .blk_last(blk_last),
`ifdef SHA224_EN
        .mode224(m224),
`endif
        .blk_ready(rdy4), .busy(busy4), .digest(dg4), .digest_valid(dv4)
    );

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h want=%h", name, got, exp);
        end
    endtask

    // Call at the negedge after the accepting edge; counts digest_valid pulses on dut1.
    task automatic collect1(output int p, output int c, output logic [255:0] d);
        p = 0; c = 0; d = '0;
        for (int k = 1; k <= 70; k++) begin
            @(posedge clk); @(negedge clk);
            if (dv1) begin p++; c = k; d = dg1; end
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int p1, p4, c1, c4;
        logic [255:0] d1, d4, exp_h;
        logic hold_bad, zero_bad;
        check($sformatf("v%0d_ready1", idx), rdy1, 1'b1);
        check($sformatf("v%0d_ready4", idx), rdy4, 1'b1);
        blk_data = v.blk; blk_first = v.first; blk_last = v.last; v1 = 1'b1; v4 = 1'b1;
        @(posedge clk); @(negedge clk);
        v1 = 1'b0; v4 = 1'b0;
        p1 = 0; p4 = 0; c1 = 0; c4 = 0; d1 = '0; d4 = '0; hold_bad = 1'b0; zero_bad = 1'b0;
        for (int k = 1; k <= 70; k++) begin
            @(posedge clk); @(negedge clk);
            exp_h = (p1 > 0) ? v.exp : hold1;
            if (dv1) begin p1++; c1 = k; d1 = dg1; end
            else if (dg1 !== exp_h) hold_bad = 1'b1;
            if (dv4) begin p4++; c4 = k; d4 = dg4; end
            else if (dg4 !== '0) zero_bad = 1'b1;
        end
        check($sformatf("v%0d_pulses1", idx), p1, v.last ? 1 : 0);
        check($sformatf("v%0d_pulses4", idx), p4, v.last ? 1 : 0);
        check($sformatf("v%0d_hold1", idx), hold_bad, 1'b0);
        check($sformatf("v%0d_zero4", idx), zero_bad, 1'b0);
        if (v.last) begin
            check($sformatf("v%0d_cycle1", idx), c1, 65);
            check($sformatf("v%0d_cycle4", idx), c4, 17);
            check($sformatf("v%0d_digest1", idx), d1, v.exp);
            check($sformatf("v%0d_digest4", idx), d4, v.exp);
            hold1 = v.exp;
        end
    endtask

    initial begin
        int p, c;
        logic [255:0] d;
        logic rbad;

        tbl[0] = '{BLK_ABC,   1'b1, 1'b1, D_ABC};
        tbl[1] = '{BLK_TWO1,  1'b1, 1'b0, 256'h0};
        tbl[2] = '{BLK_TWO2,  1'b0, 1'b1, D_TWO};
        tbl[3] = '{BLK_EMPTY, 1'b1, 1'b1, D_EMPTY};
        tbl[4] = '{BLK_ABC,   1'b1, 1'b1, D_ABC};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", rdy1, 1'b0);
        check("rst_busy", busy1, 1'b0);
        check("rst_digest", dg1, '0);
        check("rst_dvalid", dv1, 1'b0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", rdy1, 1'b1);

        for (int i = 0; i < 5; i++) run_vec(i, tbl[i]);

        // Garbage held on blk_valid while busy must neither be taken nor disturb the block.
        blk_data = BLK_EMPTY; blk_first = 1'b1; blk_last = 1'b1; v1 = 1'b1;
        @(posedge clk); @(negedge clk);
        p = 0; c = 0; d = '0; rbad = 1'b0;
        for (int k = 1; k <= 65; k++) begin
            for (int j = 0; j < 16; j++) blk_data[32*j +: 32] = $urandom;
            blk_first = k[0]; blk_last = k[1];
            @(posedge clk); @(negedge clk);
            if (dv1) begin p++; c = k; d = dg1; end
            if (k <= 64 && (rdy1 || !busy1)) rbad = 1'b1;
        end
        check("garb_ready_low", rbad, 1'b0);
        check("garb_pulses", p, 1);
        check("garb_cycle", c, 65);
        check("garb_digest", d, D_EMPTY);
        blk_data = BLK_ABC; blk_first = 1'b1; blk_last = 1'b1;
        @(posedge clk); @(negedge clk);
        v1 = 1'b0;
        collect1(p, c, d);
        check("after_garb_pulses", p, 1);
        check("after_garb_cycle", c, 65);
        check("after_garb_digest", d, D_ABC);

        // Abort a block with rst at cycle 20, then a first=0 block must start from IV.
        blk_data = BLK_TWO1; blk_first = 1'b1; blk_last = 1'b1; v1 = 1'b1;
        @(posedge clk); @(negedge clk);
        v1 = 1'b0; p = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); @(negedge clk);
            if (dv1) p++;
        end
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        if (dv1) p++;
        check("abort_ready_in_rst", rdy1, 1'b0);
        rst = 1'b0;
        #1;
        check("abort_no_pulse", p, 0);
        check("abort_ready_after", rdy1, 1'b1);
        check("abort_busy_after", busy1, 1'b0);
        blk_data = BLK_ABC; blk_first = 1'b0; blk_last = 1'b1; v1 = 1'b1;
        @(posedge clk); @(negedge clk);
        v1 = 1'b0;
        collect1(p, c, d);
        check("abort_next_pulses", p, 1);
        check("abort_next_cycle", c, 65);
        check("abort_next_digest", d, D_ABC);

`ifdef SHA224_EN
        m224 = 1'b1;
        blk_data = BLK_ABC; blk_first = 1'b1; blk_last = 1'b1; v1 = 1'b1;
        @(posedge clk); @(negedge clk);
        v1 = 1'b0; m224 = 1'b0;
        collect1(p, c, d);
        check("sha224_pulses", p, 1);
        check("sha224_digest", d,
              256'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da700000000);
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/sha256_iter_core.md
Name: sha256_iter_core

Overview:
Parametrised successor to the single-block SHA-256 FSM. It processes an arbitrary-length pre-padded message one 512-bit block at a time, chaining the hash state between blocks. It uses a valid/ready block handshake and a configurable number of rounds per clock. The message schedule is computed on the fly in a 16-word rolling window. It sits between the UART block assembler (upstream) and the signature/response logic (downstream).

Parameters:
RPC, 1, rounds computed per clock. Legal values: 1, 2, 4, 8. Elaboration error otherwise.
OUT_HOLD, 1, when 1 the digest holds its last value between results. When 0 the digest reads zero whenever digest_valid is low.

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
blk_data  in  512  message block; word W0 = [511:480], W15 = [31:0]
blk_valid  in  1  blk_data/blk_first/blk_last valid
blk_first  in  1  first block of message; reload IV before this block
blk_last  in  1  final block of message; produce a digest after this block
blk_ready  out  1  core can accept a block (high only in IDLE)
busy  out  1  block in progress (ROUND or FINAL)
digest  out  256  H0..H7; H0 = [255:224]
digest_valid  out  1  one-cycle pulse; digest is valid

Behaviour:
- Reset values: state=IDLE, H0..H7=SHA-256 IV, digest=0, digest_valid=0, busy=0, blk_ready=0 during the reset cycle and 1 afterwards.
- States:
  - IDLE: blk_ready=1. On blk_valid&blk_ready:
    - Latch W[0..15] from blk_data.
    - Load a..h from IV if blk_first, else from H.
    - Also load H=IV if blk_first.
    - Latch the last flag.
    - Clear the round counter and go to ROUND.
  - ROUND: each cycle apply RPC consecutive rounds t..t+RPC-1, using K[t] and the W window.
    - The window shifts by RPC words per cycle.
    - New words follow W[t]=σ1(W[t-2])+W[t-7]+σ0(W[t-15])+W[t-16].
    - The counter advances by RPC. After round 63 completes, go to FINAL.
  - FINAL: Hi <= Hi + working var, for i=0..7.
    - If last=1: digest <= updated H and digest_valid=1 for exactly one cycle.
    - Return to IDLE.
- Latency: the accepting edge is cycle 0. digest_valid is high in cycle 64/RPC+1 (RPC=1 → 65; RPC=4 → 17). Block-to-block throughput is 64/RPC+2 cycles.
- Arithmetic: all adds modulo 2^32. Rotations are rotr, not shifts. σ0/σ1 use rotr7^rotr18^shr3 and rotr17^rotr19^shr10. Σ0/Σ1 use rotr2^13^22 and rotr6^11^25.
- blk_valid while busy is ignored, with no side effects. The block must be held by the source until accepted.
- blk_first and blk_last both high marks a single-block message.
- First block after reset with blk_first=0: uses H (=IV after reset), so the result is identical to blk_first=1.
- Non-last block: no digest_valid; digest is unchanged (OUT_HOLD=1) or 0 (OUT_HOLD=0).
- rst mid-ROUND or mid-FINAL: aborts immediately. No digest_valid. H=IV. Next block is accepted the cycle after rst deasserts.
- Padding is the responsibility of the upstream block; the core does no length handling.

Optional Feature:
SHA224_EN
- Defined:
  - Adds input port mode224 (1 bit), sampled on an accepted block with blk_first=1.
  - When set, uses the SHA-224 IV (c1059ed8 367cd507 3070dd17 f70e5939 ffc00b31 68581511 64f98fa7 befa4fa4).
  - Output digest[255:32] = H0..H6; digest[31:0] is forced to 0.
  - Mode persists across the message's blocks; reset clears it to 0.
- Undefined: no mode224 port. SHA-256 only.

Decomposition:
- Package sha256_pkg:
  - word_t (logic[31:0])
  - K[0:63] constant array
  - IV256 and IV224 constant arrays
  - functions rotr, sig0, sig1, bsig0, bsig1, ch, maj
  - state enum {IDLE, ROUND, FINAL}
- Sub-module sha256_round: purely combinational, one compression round. Inputs are a..h, K[t] and W[t]; output is next a..h. It is instantiated RPC times in a generate chain inside the core.

Test Plan:
- "abc" single padded block, first=last=1, RPC=1 → digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, with digest_valid at cycle 65 exactly once.
- Empty message (block 80000000, rest 0), RPC=4 → e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855 at cycle 17.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (first, then last) → no pulse after block 1; after block 2 → 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- Hold blk_valid high with garbage data while busy, then present "abc" → blk_ready is 0 throughout busy and the result is unaffected (the "abc" digest); back-to-back messages with first=1 give independent digests.
- Assert rst at cycle 20 of a block → no digest_valid, blk_ready=1 the cycle after rst deasserts, and the following "abc" gives the correct digest.
- With SHA224_EN, mode224=1, "abc" → digest[255:32] = 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7, and [31:0] = 0.
